// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter.
// FSM state encoding and the bit-counter width helper.
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // bit_cnt width; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register whose registered head bit drives the serial line.
// Latency: first bit on sout one cycle after load; one bit per shift.
// Backpressure: none, the controller decides load/shift/clear every cycle.
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    // sr holds the bits still owed after the one currently on sout.
    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            sout <= 1'b0;
        end else if (load) begin
            if (MSB_FIRST) begin
                sout <= din[WIDTH-1];
                sr   <= {din[WIDTH-2:0], 1'b0};
            end else begin
                sout <= din[0];
                sr   <= {1'b0, din[WIDTH-1:1]};
            end
        end else if (shift) begin
            if (MSB_FIRST) begin
                sout <= sr[WIDTH-1];
                sr   <= {sr[WIDTH-2:0], 1'b0};
            end else begin
                sout <= sr[0];
                sr   <= {1'b0, sr[WIDTH-1:1]};
            end
        end else if (clr) begin
            sr   <= '0;
            sout <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer.
// Latency: first bit on sout one cycle after the load handshake; 1 bit/clk sustained.
// Backpressure: load_ready drops while the holding buffer is full or rst is high.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic                       sout,
    output logic                       sout_valid,
    output logic                       sout_last,
    output logic [cnt_w(WIDTH)-1:0]    bit_cnt
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic             hold_set, hold_clr;
    logic             xfer, last_bit;
    logic             sr_load, sr_shift, sr_clr;
    logic [WIDTH-1:0] sr_din;

    assign load_ready = !hold_full && !rst;
    assign xfer       = load_valid && load_ready;
    assign last_bit   = (state == ST_SHIFT) && (bit_cnt == LAST_IDX);
    assign sout_valid = (state == ST_SHIFT);
    assign sout_last  = last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_reg  <= '0;
        end else if (hold_set) begin
            hold_full <= 1'b1;
            hold_reg  <= din;
        end else if (hold_clr) begin
            hold_full <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_clr    = 1'b0;
        sr_din    = din;
        hold_set  = 1'b0;
        hold_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (xfer) begin
                    sr_load   = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    sr_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    cnt_nxt = '0;
                    // A held word wins; otherwise a same-cycle transfer bypasses the buffer.
                    if (hold_full) begin
                        sr_load  = 1'b1;
                        sr_din   = hold_reg;
                        hold_clr = 1'b1;
                    end else if (xfer) begin
                        sr_load = 1'b1;
                    end else begin
                        sr_clr    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    sr_shift = 1'b1;
                    cnt_nxt  = bit_cnt + CW'(1);
                    hold_set = xfer;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                sr_clr    = 1'b1;
            end
        endcase
    end

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .clr   (sr_clr),
        .din   (sr_din),
        .sout  (sout)
    );

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first instances share one stimulus stream.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] din;

    logic       lr0, so0, sv0, sl0;
    logic [2:0] bc0;
    logic       lr1, so1, sv1, sl1;
    logic [2:0] bc1;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(lr0),
        .sout(so0), .sout_valid(sv0), .sout_last(sl0), .bit_cnt(bc0)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(lr1),
        .sout(so1), .sout_valid(sv1), .sout_last(sl1), .bit_cnt(bc1)
    );

    typedef struct packed {
        logic       b;
        logic       last;
        logic [2:0] idx;
    } exp_t;

    // Per-instance queue of bits still owed on the serial line, in transmit order.
    exp_t q[2][$];
    int   tests  = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", name, d, $time, act, exp);
        end
    endtask

    function automatic void push_word(input logic [W-1:0] w);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < W; k++) begin
                e.b    = (d == 0) ? w[W-1-k] : w[k];
                e.last = (k == W - 1);
                e.idx  = 3'(k);
                q[d].push_back(e);
            end
        end
    endfunction

    // Line must be busy exactly while bits are owed; more than one word owed means the buffer is full.
    task automatic mon_one(input int d, input logic v, input logic s, input logic l,
                           input logic [2:0] c, input logic r);
        exp_t e;
        if (q[d].size() > 0) begin
            e = q[d].pop_front();
            check("sout_valid", d, 32'(v), 32'd1);
            check("sout", d, 32'(s), 32'(e.b));
            check("sout_last", d, 32'(l), 32'(e.last));
            check("bit_cnt", d, 32'(c), 32'(e.idx));
        end else begin
            check("idle_valid", d, 32'(v), 32'd0);
            check("idle_sout", d, 32'(s), 32'd0);
            check("idle_last", d, 32'(l), 32'd0);
            check("idle_bit_cnt", d, 32'(c), 32'd0);
        end
        check("load_ready", d, 32'(r), 32'(!rst && (q[d].size() < W)));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0, sv0, so0, sl0, bc0, lr0);
            mon_one(1, sv1, so1, sl1, bc1, lr1);
            if (rst) begin
                q[0].delete();
                q[1].delete();
            end else if (load_valid && lr0) begin
                push_word(din);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        int n = 0;
        din        = w;
        load_valid = 1'b1;
        while (!lr0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n >= 40) begin
            fails++;
            $display("FAIL send_timeout word=%0h waited=%0d cycles", w, n);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        load_valid = 1'b1;
        din        = 8'hFF;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        idle(2);

        send(8'hA5);
        idle(10);
        send(8'h01);
        idle(10);

        // Second word lands in the holding buffer while the first shifts.
        send(8'hF0);
        send(8'h0F);
        idle(20);

        // Transfer on the last-bit cycle with the buffer empty.
        send(8'h00);
        idle(7);
        send(8'h81);
        idle(12);

        // Reset at bit 3 with a word held.
        send(8'h33);
        send(8'hCC);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(8'h5A);
        idle(12);

        for (int i = 0; i < 400; i++) begin
            load_valid = ($urandom_range(0, 3) != 0);
            din        = W'($urandom);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;

        n = 0;
        while ((q[0].size() > 0 || q[1].size() > 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (q[0].size() > 0 || q[1].size() > 0) begin
            fails++;
            $display("FAIL drain remaining=%0d/%0d expected=0", q[0].size(), q[1].size());
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
